conv_window_streamer: RTL and testbench

- Transmit-side counterpart of the convolution accelerator's 64-bit AXI-Stream input.
- Buffers one CONV_SIZE×CONV_SIZE single-precision image and one KERNEL_SIZE×KERNEL_SIZE kernel, loaded over a simple word port.
- On `start`, streams every {kernel coefficient, pixel} operand pair of a valid-mode 2-D convolution as AXIS beats, with TLAST closing each output window.
- Sits between the host-side loader and the accelerator input port.

---
 rtl/conv_window_streamer_if.sv | 28 ++
 rtl/conv_window_streamer.sv | 212 +++++++++++++++++++++
 tb/tb_conv_window_streamer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_streamer_if.sv
// Bus bundle for conv_window_streamer: word load port, run control and 64-bit AXI-Stream master.
// master = streamer side, slave = host loader / downstream sink side.
interface conv_window_streamer_if #(
   parameter int TDATA_WIDTH = 64
);
   logic                     ld_valid;
   logic                     ld_ready;
   logic [31:0]              ld_data;
   logic                     ld_kernel;
   logic                     start;
   logic                     busy;
   logic                     done;
   logic                     M_AXIS_TVALID;
   logic [TDATA_WIDTH-1:0]   M_AXIS_TDATA;
   logic [TDATA_WIDTH/8-1:0] M_AXIS_TSTRB;
   logic                     M_AXIS_TLAST;
   logic                     M_AXIS_TREADY;

   modport master (
      input  ld_valid, ld_data, ld_kernel, start, M_AXIS_TREADY,
      output ld_ready, busy, done, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
   );

   modport slave (
      output ld_valid, ld_data, ld_kernel, start, M_AXIS_TREADY,
      input  ld_ready, busy, done, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST
   );
endinterface

// File: rtl/conv_window_streamer.sv
// Buffers an image and kernel, then streams {coeff, pixel} pairs for every 2-D convolution tap.
// Define CONV_STREAM_PAD_EN for zero-padded "same" convolution; default is valid mode.
module conv_window_streamer #(
   parameter int C_M_AXIS_TDATA_WIDTH = 64,
   parameter int CONV_SIZE            = 8,
   parameter int KERNEL_SIZE          = 3
) (
   input logic                    M_AXIS_ACLK,
   input logic                    M_AXIS_ARESETN,
   conv_window_streamer_if.master bus
);
   localparam int IMG_N = CONV_SIZE * CONV_SIZE;
   localparam int KER_N = KERNEL_SIZE * KERNEL_SIZE;
   localparam int IW    = $clog2(IMG_N + 1);
   localparam int KW    = $clog2(KER_N + 1);
   localparam int AW    = (IMG_N > 1) ? $clog2(IMG_N) : 1;
   localparam int KAW   = (KER_N > 1) ? $clog2(KER_N) : 1;
`ifdef CONV_STREAM_PAD_EN
   localparam int OUT   = CONV_SIZE;
   localparam int PAD   = (KERNEL_SIZE - 1) / 2;
`else
   localparam int OUT   = CONV_SIZE - KERNEL_SIZE + 1;
`endif
   localparam int OW    = (OUT > 1) ? $clog2(OUT) : 1;
   localparam int TW    = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int SW    = ((OW > TW) ? OW : TW) + 1;

   typedef enum logic [1:0] {S_LOAD, S_ARMED, S_STREAM, S_DONE} state_t;

   state_t                          state_q, state_d;
   logic [IW-1:0]                   img_cnt_q, img_cnt_d;
   logic [KW-1:0]                   ker_cnt_q, ker_cnt_d;
   logic [OW-1:0]                   oy_q, oy_d, ox_q, ox_d;
   logic [TW-1:0]                   ky_q, ky_d, kx_q, kx_d;
   logic                            tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic                            busy_q, busy_d, done_q, done_d;
   logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;

   logic [31:0] image_mem  [IMG_N];
   logic [31:0] kernel_mem [KER_N];

   logic            img_full, ker_full, ld_ready, ld_fire, last_beat;
   logic [OW-1:0]   nxt_oy, nxt_ox, sel_oy, sel_ox;
   logic [TW-1:0]   nxt_ky, nxt_kx, sel_ky, sel_kx;
   logic [SW-1:0]   row_idx, col_idx;
   logic [AW-1:0]   img_addr;
   logic [KAW-1:0]  ker_addr;
   logic [31:0]     pixel, coeff;
   logic            sel_tap_last;

   assign img_full = (img_cnt_q == IW'(IMG_N));
   assign ker_full = (ker_cnt_q == KW'(KER_N));
   assign ld_ready = M_AXIS_ARESETN && (state_q == S_LOAD) &&
                     !(bus.ld_kernel ? ker_full : img_full);
   assign ld_fire  = bus.ld_valid && ld_ready;

   always_ff @(posedge M_AXIS_ACLK) begin
      if (ld_fire && bus.ld_kernel) kernel_mem[ker_cnt_q[KAW-1:0]] <= bus.ld_data;
      if (ld_fire && !bus.ld_kernel) image_mem[img_cnt_q[AW-1:0]] <= bus.ld_data;
   end

   // Successor of the tap currently held in the output register.
   always_comb begin
      nxt_kx = kx_q + 1'b1;
      nxt_ky = ky_q;
      nxt_ox = ox_q;
      nxt_oy = oy_q;
      if (kx_q == TW'(KERNEL_SIZE - 1)) begin
         nxt_kx = '0;
         if (ky_q == TW'(KERNEL_SIZE - 1)) begin
            nxt_ky = '0;
            if (ox_q == OW'(OUT - 1)) begin
               nxt_ox = '0;
               nxt_oy = (oy_q == OW'(OUT - 1)) ? '0 : oy_q + 1'b1;
            end else begin
               nxt_ox = ox_q + 1'b1;
            end
         end else begin
            nxt_ky = ky_q + 1'b1;
         end
      end
   end

   assign last_beat = (kx_q == TW'(KERNEL_SIZE - 1)) && (ky_q == TW'(KERNEL_SIZE - 1)) &&
                      (ox_q == OW'(OUT - 1)) && (oy_q == OW'(OUT - 1));

   // ARMED fetches beat 0 so it lands in the output register with the start.
   assign sel_oy = (state_q == S_ARMED) ? '0 : nxt_oy;
   assign sel_ox = (state_q == S_ARMED) ? '0 : nxt_ox;
   assign sel_ky = (state_q == S_ARMED) ? '0 : nxt_ky;
   assign sel_kx = (state_q == S_ARMED) ? '0 : nxt_kx;
   assign sel_tap_last = (sel_ky == TW'(KERNEL_SIZE - 1)) && (sel_kx == TW'(KERNEL_SIZE - 1));

   assign ker_addr = KAW'(sel_ky) * KAW'(KERNEL_SIZE) + KAW'(sel_kx);
   assign coeff    = kernel_mem[ker_addr];

`ifdef CONV_STREAM_PAD_EN
   logic [SW-1:0] row_sum, col_sum;
   logic          in_range;
   assign row_sum  = SW'(sel_oy) + SW'(sel_ky);
   assign col_sum  = SW'(sel_ox) + SW'(sel_kx);
   // Shifted sums stay unsigned: a coordinate below PAD is the top/left halo.
   assign in_range = (row_sum >= SW'(PAD)) && (row_sum < SW'(CONV_SIZE + PAD)) &&
                     (col_sum >= SW'(PAD)) && (col_sum < SW'(CONV_SIZE + PAD));
   assign row_idx  = row_sum - SW'(PAD);
   assign col_idx  = col_sum - SW'(PAD);
   assign img_addr = AW'(row_idx) * AW'(CONV_SIZE) + AW'(col_idx);
   assign pixel    = in_range ? image_mem[img_addr] : 32'h0;
`else
   assign row_idx  = SW'(sel_oy) + SW'(sel_ky);
   assign col_idx  = SW'(sel_ox) + SW'(sel_kx);
   assign img_addr = AW'(row_idx) * AW'(CONV_SIZE) + AW'(col_idx);
   assign pixel    = image_mem[img_addr];
`endif

   always_comb begin
      state_d   = state_q;
      img_cnt_d = img_cnt_q;
      ker_cnt_d = ker_cnt_q;
      oy_d      = oy_q;
      ox_d      = ox_q;
      ky_d      = ky_q;
      kx_d      = kx_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      tdata_d   = tdata_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (ld_fire && bus.ld_kernel) ker_cnt_d = ker_cnt_q + 1'b1;
            if (ld_fire && !bus.ld_kernel) img_cnt_d = img_cnt_q + 1'b1;
            if ((img_cnt_d == IW'(IMG_N)) && (ker_cnt_d == KW'(KER_N))) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (bus.start) begin
               state_d  = S_STREAM;
               busy_d   = 1'b1;
               tvalid_d = 1'b1;
               tdata_d  = {coeff, pixel};
               tlast_d  = sel_tap_last;
               oy_d     = '0;
               ox_d     = '0;
               ky_d     = '0;
               kx_d     = '0;
            end
         end
         S_STREAM: begin
            if (tvalid_q && bus.M_AXIS_TREADY) begin
               if (last_beat) begin
                  state_d  = S_DONE;
                  tvalid_d = 1'b0;
                  tlast_d  = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  oy_d    = nxt_oy;
                  ox_d    = nxt_ox;
                  ky_d    = nxt_ky;
                  kx_d    = nxt_kx;
                  tdata_d = {coeff, pixel};
                  tlast_d = sel_tap_last;
               end
            end
         end
         S_DONE: begin
            state_d   = S_LOAD;
            img_cnt_d = '0;
            ker_cnt_d = '0;
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge M_AXIS_ACLK) begin
      if (!M_AXIS_ARESETN) begin
         state_q   <= S_LOAD;
         img_cnt_q <= '0;
         ker_cnt_q <= '0;
         oy_q      <= '0;
         ox_q      <= '0;
         ky_q      <= '0;
         kx_q      <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         tdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         img_cnt_q <= img_cnt_d;
         ker_cnt_q <= ker_cnt_d;
         oy_q      <= oy_d;
         ox_q      <= ox_d;
         ky_q      <= ky_d;
         kx_q      <= kx_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         tdata_q   <= tdata_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.ld_ready      = ld_ready;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.M_AXIS_TVALID = tvalid_q;
   assign bus.M_AXIS_TDATA  = tdata_q;
   assign bus.M_AXIS_TSTRB  = '1;
   assign bus.M_AXIS_TLAST  = tlast_q;
endmodule

// File: tb/tb_conv_window_streamer.sv
// Directed bench for conv_window_streamer: load, stream, backpressure, start gating, reset mid-run.
module tb_conv_window_streamer;
   localparam int N = 8;
   localparam int K = 3;
`ifdef CONV_STREAM_PAD_EN
   localparam int OUT = N;
   localparam int P   = 1;
   localparam logic [63:0] BP_EXP = 64'h10000004_00000000;
`else
   localparam int OUT = N - K + 1;
   localparam int P   = 0;
   localparam logic [63:0] BP_EXP = 64'h10000004_00000009;
`endif
   localparam int TOTAL = OUT * OUT * K * K;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   conv_window_streamer_if bus_if ();

   conv_window_streamer #(
      .C_M_AXIS_TDATA_WIDTH(64),
      .CONV_SIZE(N),
      .KERNEL_SIZE(K)
   ) dut (
      .M_AXIS_ACLK(clk),
      .M_AXIS_ARESETN(rstn),
      .bus(bus_if)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] cap      [0:1023];
   logic        cap_last [0:1023];
   int nb, nd, nbad, nx;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [63:0] exp_beat(input int b);
      int w, t, r, c, pix;
      w = b / (K * K);
      t = b % (K * K);
      r = w / OUT + t / K - P;
      c = w % OUT + t % K - P;
      pix = (r >= 0 && r < N && c >= 0 && c < N) ? r * N + c : 0;
      return {32'h10000000 + 32'(t), 32'(pix)};
   endfunction

   task automatic load_word(input logic kern, input logic [31:0] d, input logic with_start);
      logic ok;
      ok = 1'b0;
      bus_if.ld_valid  = 1'b1;
      bus_if.ld_kernel = kern;
      bus_if.ld_data   = d;
      bus_if.start     = with_start;
      #1;
      for (int i = 0; i < 20; i++) begin
         if (bus_if.ld_ready) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
         #1;
      end
      bus_if.ld_valid = 1'b0;
      bus_if.start    = 1'b0;
      if (!ok) chk("ld_timeout", 64'(ok), 64'd1);
   endtask

   task automatic load_basic(input logic start_on_last);
      for (int i = 0; i < N * N; i++) load_word(1'b0, 32'(i), 1'b0);
      for (int j = 0; j < K * K; j++)
         load_word(1'b1, 32'h10000000 + 32'(j), start_on_last && (j == K * K - 1));
   endtask

   task automatic run_stream(input int bp_at, input int rst_at, input int sb_at,
                             output int nbeats, output int ndone, output int nbad_o,
                             output int nextra);
      int bp_cnt, post;
      bp_cnt = 0; post = 0; nbeats = 0; ndone = 0; nbad_o = 0; nextra = 0;
      @(negedge clk);
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      chk("start_lat_tvalid", 64'(bus_if.M_AXIS_TVALID), 64'd1);
      chk("start_lat_busy", 64'(bus_if.busy), 64'd1);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (bus_if.done) ndone++;
         if (bus_if.M_AXIS_TVALID && ndone > 0) nextra++;
         if (ndone > 0) begin
            post++;
            if (post > 5) break;
         end
         if (rst_at >= 0 && nbeats == rst_at) begin
            rstn = 1'b0;
            @(negedge clk);
            chk("rst_tvalid", 64'(bus_if.M_AXIS_TVALID), 64'd0);
            chk("rst_busy", 64'(bus_if.busy), 64'd0);
            rstn = 1'b1;
            bus_if.ld_kernel = 1'b0;
            @(negedge clk);
            #1;
            chk("rst_ld_ready", 64'(bus_if.ld_ready), 64'd1);
            break;
         end
         bus_if.start = (sb_at >= 0 && nbeats == sb_at);
         if (bp_at >= 0 && nbeats == bp_at && bp_cnt < 5) begin
            bus_if.M_AXIS_TREADY = 1'b0;
            bp_cnt++;
            chk("bp_tdata", bus_if.M_AXIS_TDATA, BP_EXP);
            chk("bp_tvalid", 64'(bus_if.M_AXIS_TVALID), 64'd1);
         end else begin
            bus_if.M_AXIS_TREADY = 1'b1;
         end
         if (bus_if.M_AXIS_TVALID && bus_if.M_AXIS_TREADY) begin
            if (nbeats < 1024) begin
               cap[nbeats]      = bus_if.M_AXIS_TDATA;
               cap_last[nbeats] = bus_if.M_AXIS_TLAST;
            end
            if (bus_if.M_AXIS_TDATA !== exp_beat(nbeats) ||
                bus_if.M_AXIS_TLAST !== ((nbeats % (K * K)) == K * K - 1))
               nbad_o++;
            nbeats++;
         end
         @(negedge clk);
      end
      bus_if.start = 1'b0;
      bus_if.M_AXIS_TREADY = 1'b1;
   endtask

   task automatic chk_full_run(input string tag);
      chk({tag, "_beats"}, 64'(nb), 64'(TOTAL));
      chk({tag, "_done_pulses"}, 64'(nd), 64'd1);
      chk({tag, "_bad_beats"}, 64'(nbad), 64'd0);
      chk({tag, "_beats_after_done"}, 64'(nx), 64'd0);
      $display("run %s: beats=%0d done=%0d bad=%0d extra=%0d", tag, nb, nd, nbad, nx);
   endtask

   initial begin
      bus_if.ld_valid      = 1'b0;
      bus_if.ld_kernel     = 1'b0;
      bus_if.ld_data       = 32'h0;
      bus_if.start         = 1'b0;
      bus_if.M_AXIS_TREADY = 1'b1;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ld_ready", 64'(bus_if.ld_ready), 64'd0);
      chk("rst_busy", 64'(bus_if.busy), 64'd0);
      chk("rst_done", 64'(bus_if.done), 64'd0);
      chk("rst_tvalid", 64'(bus_if.M_AXIS_TVALID), 64'd0);
      chk("rst_tlast", 64'(bus_if.M_AXIS_TLAST), 64'd0);
      chk("rst_tdata", bus_if.M_AXIS_TDATA, 64'd0);
      chk("rst_tstrb", 64'(bus_if.M_AXIS_TSTRB), 64'hFF);
      rstn = 1'b1;
      @(negedge clk);
      #1;
      chk("ld_ready_after_release", 64'(bus_if.ld_ready), 64'd1);

      // Start during LOAD must be ignored
      @(negedge clk);
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("load_start_tvalid", 64'(bus_if.M_AXIS_TVALID), 64'd0);
         @(negedge clk);
      end

      // Basic load; start coincident with the last fill is ignored
      load_basic(1'b1);
      chk("fill_start_tvalid", 64'(bus_if.M_AXIS_TVALID), 64'd0);
      chk("fill_start_busy", 64'(bus_if.busy), 64'd0);
      @(negedge clk);
      #1;
      chk("fill_start_tvalid2", 64'(bus_if.M_AXIS_TVALID), 64'd0);
      chk("armed_ld_ready", 64'(bus_if.ld_ready), 64'd0);

      run_stream(-1, -1, -1, nb, nd, nbad, nx);
      chk_full_run("basic");
`ifdef CONV_STREAM_PAD_EN
      chk("pad_beat0", cap[0], 64'h10000000_00000000);
      chk("pad_beat4", cap[4], 64'h10000004_00000000);
      chk("pad_beat8", cap[8], 64'h10000008_00000009);
      chk("pad_beat8_last", 64'(cap_last[8]), 64'd1);
`else
      chk("beat0", cap[0], 64'h10000000_00000000);
      chk("beat8", cap[8], 64'h10000008_00000012);
      chk("beat8_last", 64'(cap_last[8]), 64'd1);
      chk("beat9", cap[9], 64'h10000000_00000001);
      chk("beat9_last", 64'(cap_last[9]), 64'd0);
      chk("beat323", cap[323], 64'h10000008_0000003F);
      chk("beat323_last", 64'(cap_last[323]), 64'd1);
`endif

      // Interleaved load with a surplus kernel word; start pulsed mid-stream
      for (int i = 0; i < N * N; i++) begin
         if (i < K * K) load_word(1'b1, 32'h10000000 + 32'(i), 1'b0);
         load_word(1'b0, 32'(i), 1'b0);
         if (i == K * K) begin
            bus_if.ld_valid  = 1'b1;
            bus_if.ld_kernel = 1'b1;
            bus_if.ld_data   = 32'hDEADBEEF;
            #1;
            chk("extra_ker_stall0", 64'(bus_if.ld_ready), 64'd0);
            @(negedge clk);
            #1;
            chk("extra_ker_stall1", 64'(bus_if.ld_ready), 64'd0);
            bus_if.ld_valid = 1'b0;
            @(negedge clk);
         end
      end
      run_stream(-1, -1, 50, nb, nd, nbad, nx);
      chk_full_run("interleaved_busy_start");
      bus_if.ld_kernel = 1'b1;
      #1;
      chk("ker_ready_after_done", 64'(bus_if.ld_ready), 64'd1);

      // Backpressure at beat 4
      load_basic(1'b0);
      run_stream(4, -1, -1, nb, nd, nbad, nx);
      chk_full_run("backpressure");

      // Reset mid-stream at beat 100, then a clean run to confirm recovery
      load_basic(1'b0);
      run_stream(-1, 100, -1, nb, nd, nbad, nx);
      chk("midrst_beats", 64'(nb), 64'd100);
      chk("midrst_bad", 64'(nbad), 64'd0);
      $display("run midrst: beats=%0d bad=%0d", nb, nbad);
      load_basic(1'b0);
      run_stream(-1, -1, -1, nb, nd, nbad, nx);
      chk_full_run("after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
